// File: rtl/pipe_scheduler.sv
// pipe_scheduler: play/pause/game-over control of the scrolling pipe, stepped once per video frame.
module pipe_scheduler #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int PIPE_WIDTH    = 50,
   parameter int TICK_LINE     = 480,
   parameter int BASE_SPEED    = 2,
   parameter int MAX_SPEED     = 8,
   parameter int GAP_MIN       = 40,
   parameter int GAP_SIZE      = 120
) (
   input  logic        clk,
   input  logic        clear_n,
   input  logic [9:0]  h_counter,
   input  logic [9:0]  v_counter,
   input  logic        start,
   input  logic        pause,
   input  logic        collide,
   output logic [10:0] pipe_r,
   output logic [9:0]  gap_top,
   output logic [9:0]  gap_bot,
   output logic        pipe_on,
   output logic [1:0]  state,
   output logic [7:0]  score,
   output logic [3:0]  speed
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] PAUSED = 2'd2;
   localparam logic [1:0] OVER   = 2'd3;
   localparam logic [10:0] PIPE_START = 11'(SCREEN_WIDTH + PIPE_WIDTH);
   logic [1:0]  r_state;
   logic [10:0] r_pipe_r;
   logic [9:0]  r_gap_top;
   logic [7:0]  r_score;
   logic [7:0]  r_lfsr;
   logic        r_match;
   logic        r_tick;
   logic        w_match;
   logic        w_init;
   logic        w_wrap;
   logic [5:0]  w_speed_sum;
   logic [9:0]  w_gap_new;
   logic [7:0]  w_score_inc;
   always_comb begin
      w_match     = (h_counter == 10'd0) && (v_counter == 10'(TICK_LINE));
      w_init      = start && (r_state == IDLE || r_state == OVER);
      w_speed_sum = 6'(BASE_SPEED) + {1'b0, r_score[7:3]};
      speed       = (w_speed_sum > 6'(MAX_SPEED)) ? 4'(MAX_SPEED) : w_speed_sum[3:0];
      w_wrap      = r_pipe_r <= {7'd0, speed};
      w_gap_new   = 10'(GAP_MIN) + {2'd0, r_lfsr};
      w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
   end
   // x^8+x^6+x^5+x^4+1 shifting left; the nonzero seed keeps it out of the all-zero lockup
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_lfsr  <= 8'hA5;
         r_match <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_match <= w_match;
         r_tick  <= w_match & ~r_match;
      end
   end
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state   <= IDLE;
         r_pipe_r  <= PIPE_START;
         r_gap_top <= 10'(GAP_MIN);
         r_score   <= 8'd0;
      end else if (w_init) begin
         r_state   <= RUN;
         r_pipe_r  <= PIPE_START;
         r_gap_top <= w_gap_new;
         r_score   <= 8'd0;
      end else if (r_state == RUN) begin
         if (collide)
            r_state <= OVER;
         else if (pause)
            r_state <= PAUSED;
         else if (r_tick && w_wrap) begin
            r_pipe_r  <= PIPE_START;
            r_gap_top <= w_gap_new;
            r_score   <= w_score_inc;
         end else if (r_tick)
            r_pipe_r <= r_pipe_r - {7'd0, speed};
      end else if (r_state == PAUSED && pause)
         r_state <= RUN;
   end
   assign state   = r_state;
   assign pipe_r  = r_pipe_r;
   assign gap_top = r_gap_top;
   assign gap_bot = r_gap_top + 10'(GAP_SIZE);
   assign score   = r_score;
   assign pipe_on = r_state != IDLE;
endmodule
